ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The block SHALL take parameter XLEN, default 64, which sets the datapath width; only 64 is supported.
REQ-002 The block SHALL use a single clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- valid_in  input  1  EX-stage instruction valid (low for a bubble)
- opcode_in  input  7  EX-stage opcode
- func3_in  input  3  EX-stage funct3
- func70_in  input  1  funct7 bit 0 (M-extension select)
- rs1_val  input  64  forwarded operand A
- rs2_val  input  64  forwarded operand B
- rd_in  input  5  EX-stage destination register
- flush  input  1  kill the in-flight operation
- stall_out  output  1  stall request, ORed into StallE and upstream stalls
- result_valid  output  1  result present this cycle
- result  output  64  M-extension result
- rd_out  output  5  destination register of result

Function
REQ-003 m_op SHALL be valid_in & func70_in & (opcode_in==0110011 | (opcode_in==0111011 & func3_in in {000,100,101,110,111})).
REQ-004 The FSM SHALL have three states, IDLE, CALC and DONE, with these transitions:
- IDLE->CALC on m_op with a normal operation.
- IDLE->DONE on m_op with a special case (REQ-010).
- CALC->DONE after iteration counter reaches 63.
- DONE->IDLE unconditionally, with no re-accept in DONE.
REQ-005 On acceptance in IDLE, the block SHALL latch operands, func3, W-flag and rd_in; inputs SHALL be ignored in CALC and DONE.
REQ-006 stall_out SHALL be combinational: (IDLE & m_op) | CALC, forced 0 when flush=1; it SHALL be 0 in DONE.
REQ-007 Latency for an acceptance in cycle T SHALL be as follows:
- CALC runs in cycles T+1..T+64 using a 6-bit iteration counter.
- DONE is in T+65 with result_valid=1.
- stall_out is high T..T+64.
REQ-008 Multiply SHALL be a radix-2 shift-add over 64 iterations on magnitudes, with sign fixup at the end. The func3 encodings SHALL select:
- 000 MUL: low 64 bits.
- 001 MULH: signed x signed, high 64 bits.
- 010 MULHSU: signed x unsigned, high 64 bits.
- 011 MULHU: unsigned x unsigned, high 64 bits.
REQ-009 Divide SHALL be restoring, 64 iterations, on magnitudes. The func3 encodings SHALL select:
- 100 DIV: quotient sign = sign(A) xor sign(B).
- 101 DIVU.
- 110 REM: remainder sign = sign(A).
- 111 REMU.
REQ-010 Special cases SHALL go IDLE->DONE, with result_valid in T+1:
- Divide by zero: quotient = all ones; remainder = A.
- Signed overflow (A = most negative, B = -1): quotient = A; remainder = 0.
REQ-011 W-ops SHALL use operands rs1_val[31:0] and rs2_val[31:0], sign- or zero-extended per op.
- The final result SHALL be sign-extended from bit 31.
- Special cases SHALL be evaluated at 32-bit width.
REQ-012 result and rd_out SHALL be registered and updated only on entry to DONE; they SHALL hold their values until the next completion.
REQ-013 result_valid SHALL be high exactly one cycle per completed operation.
REQ-014 flush in any state SHALL force IDLE next cycle, suppress result_valid and leave result unchanged.
REQ-015 flush together with m_op in IDLE SHALL not accept the operation.

Reset
REQ-016 reset=1 at a clock edge SHALL force state IDLE, counter 0, result_valid 0, result 0 and rd_out 0.
REQ-017 reset mid-CALC SHALL abort the operation; no result_valid SHALL follow.
REQ-018 stall_out SHALL be 0 in the first cycle after reset unless m_op is asserted.

Verification
REQ-019 MUL: A=7, B=-3, rd=5 -> stall_out high 65 cycles; result_valid in T+65 with result=0xFFFFFFFFFFFFFFEB and rd_out=5.
REQ-020 MULHU: A=B=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE at T+65; MULH of the same operands -> result=0.
REQ-021 DIV: A=-20, B=6 -> result=-3; REM on the same operands -> result=-2; DIVW: A=0x80000000, B=0xFFFFFFFF -> result=0xFFFFFFFF80000000 at T+1.
REQ-022 DIVU: A=123, B=0 -> result=0xFFFFFFFFFFFFFFFF at T+1; REMU on the same operands -> result=123; stall_out high only in cycle T.
REQ-023 flush at T+20 of a DIV -> stall_out drops in the same cycle; IDLE at T+21; no result_valid; result holds its previous value.
REQ-024 reset at T+30, then a new MUL of 2x3 -> clean restart, result=6 at 65 cycles after acceptance; a bubble (valid_in=0) with an M opcode -> stall_out stays 0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage: 64-cycle shift-add multiply,
// restoring divide, and single-cycle handling of divide-by-zero and signed overflow.
module ex_muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      func3_in,
  input  logic            func70_in,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall_out,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [5:0]      cnt;
  logic [2:0]      func3_q;
  logic            w_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] mcand;

  logic            is_w;
  logic            m_op;
  logic            a_signed;
  logic            b_signed;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_sx;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign is_w = (opcode_in == 7'b0111011);
  assign m_op = valid_in & func70_in &
                ((opcode_in == 7'b0110011) | (is_w & ((func3_in == 3'b000) | func3_in[2])));

  // Operand signedness follows the op: MULH/MULHSU/DIV/REM treat A as signed, MULH/DIV/REM treat B as signed.
  assign a_signed = (func3_in == 3'b001) | (func3_in == 3'b010) | (func3_in[2] & ~func3_in[0]);
  assign b_signed = (func3_in == 3'b001) | (func3_in[2] & ~func3_in[0]);

  assign a_ext = is_w ? {{(XLEN-32){a_signed & rs1_val[31]}}, rs1_val[31:0]} : rs1_val;
  assign b_ext = is_w ? {{(XLEN-32){b_signed & rs2_val[31]}}, rs2_val[31:0]} : rs2_val;
  assign a_sx  = is_w ? {{(XLEN-32){rs1_val[31]}}, rs1_val[31:0]} : rs1_val;

  assign a_neg = a_signed & a_ext[XLEN-1];
  assign b_neg = b_signed & b_ext[XLEN-1];
  assign mag_a = a_neg ? -a_ext : a_ext;
  assign mag_b = b_neg ? -b_ext : b_ext;

  // Special cases are judged at the operation's own width so DIVW overflow is caught on 32-bit values.
  assign div_zero = func3_in[2] & (b_ext == '0);
  assign div_ovf  = func3_in[2] & ~func3_in[0] &
                    (is_w ? ((rs1_val[31:0] == 32'h8000_0000) & (rs2_val[31:0] == 32'hFFFF_FFFF))
                          : ((rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1)));
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = func3_in[1] ? a_sx : '1;
    else
      special_res = func3_in[1] ? '0 : a_sx;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [XLEN-1:0]   hi_nx;
  logic [XLEN-1:0]   lo_nx;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   raw_res;
  logic [XLEN-1:0]   final_res;

  // One iteration: multiply adds the multiplicand then shifts right; divide shifts left and keeps the trial subtract if it did not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, mcand};
    hi_nx     = acc_hi;
    lo_nx     = acc_lo;
    if (func3_q[2]) begin
      if (!div_trial[XLEN]) begin
        hi_nx = div_trial[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = div_shift[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod      = {hi_nx, lo_nx};
    prod_fix  = (a_neg_q ^ b_neg_q) ? -prod : prod;
    quot_fix  = (a_neg_q ^ b_neg_q) ? -lo_nx : lo_nx;
    rem_fix   = a_neg_q ? -hi_nx : hi_nx;
    raw_res   = '0;
    case (func3_q)
      3'b000:                 raw_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: raw_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         raw_res = quot_fix;
      default:                raw_res = rem_fix;
    endcase
    final_res = w_q ? {{(XLEN-32){raw_res[31]}}, raw_res[31:0]} : raw_res;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (m_op && !flush) state_nx = special ? DONE : CALC;
      CALC: begin
        if (flush)
          state_nx = IDLE;
        else if (cnt == 6'd63)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign stall_out    = ~flush & (((state == IDLE) & m_op) | (state == CALC));
  assign result_valid = (state == DONE) & ~flush;

  // Operands go in as magnitudes; the multiplier (or dividend) sits in acc_lo and is consumed one bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      func3_q <= '0;
      w_q     <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      rd_q    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_op && !flush) begin
            func3_q <= func3_in;
            w_q     <= is_w;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            rd_q    <= rd_in;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= func3_in[2] ? mag_a : mag_b;
            mcand   <= func3_in[2] ? mag_b : mag_a;
            if (special) begin
              result <= special_res;
              rd_out <= rd_in;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc_hi <= hi_nx;
            acc_lo <= lo_nx;
            cnt    <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              result <= final_res;
              rd_out <= rd_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed corner cases plus random M-extension ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [6:0]  opcode_in = '0;
  logic [2:0]  func3_in = '0;
  logic        func70_in = 1'b0;
  logic [63:0] rs1_val = '0;
  logic [63:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        stall_out;
  logic        result_valid;
  logic [63:0] result;
  logic [4:0]  rd_out;

  ex_muldiv_unit #(.XLEN(64)) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .opcode_in(opcode_in),
    .func3_in(func3_in),
    .func70_in(func70_in),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .rd_in(rd_in),
    .flush(flush),
    .stall_out(stall_out),
    .result_valid(result_valid),
    .result(result),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          doneCycle;
    int          stallCycles;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          nComp = 0;
  int          nFail = 0;
  int          stallRun = 0;
  logic [63:0] lastResult = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: straight RISC-V M semantics using wide arithmetic.
  function automatic logic [63:0] refModel(input logic [2:0] f3, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       pa, pb, p;
    logic signed [63:0] sa, sb64;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        r32;
    logic [63:0]        r64;
    logic               ovf;
    if (!f3[2]) begin
      if (w) begin
        p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
        return {{32{p[31]}}, p[31:0]};
      end
      pa = (f3 == 3'b001 || f3 == 3'b010) ? {{64{a[63]}}, a} : {64'b0, a};
      pb = (f3 == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = pa * pb;
      return (f3 == 3'b000) ? p[63:0] : p[127:64];
    end
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      ovf  = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
      r32  = '0;
      case (f3)
        3'b100: begin
          if (b[31:0] == 0) r32 = 32'hFFFF_FFFF;
          else if (ovf)     r32 = a[31:0];
          else              r32 = sa32 / sb32;
        end
        3'b101: begin
          if (b[31:0] == 0) r32 = 32'hFFFF_FFFF;
          else              r32 = a[31:0] / b[31:0];
        end
        3'b110: begin
          if (b[31:0] == 0) r32 = a[31:0];
          else if (ovf)     r32 = 32'h0;
          else              r32 = sa32 % sb32;
        end
        default: begin
          if (b[31:0] == 0) r32 = a[31:0];
          else              r32 = a[31:0] % b[31:0];
        end
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa   = a;
    sb64 = b;
    ovf  = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    r64  = '0;
    case (f3)
      3'b100: begin
        if (b == 0)   r64 = '1;
        else if (ovf) r64 = a;
        else          r64 = sa / sb64;
      end
      3'b101: begin
        if (b == 0) r64 = '1;
        else        r64 = a / b;
      end
      3'b110: begin
        if (b == 0)   r64 = a;
        else if (ovf) r64 = '0;
        else          r64 = sa % sb64;
      end
      default: begin
        if (b == 0) r64 = a;
        else        r64 = a % b;
      end
    endcase
    return r64;
  endfunction

  function automatic bit isSpecial(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (!f3[2]) return 1'b0;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    return zero || ovf;
  endfunction

  // Issues one op in a single cycle T; when tracked, the expected completion goes to the scoreboard.
  task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] rd, input bit track);
    exp_t e;
    int   lat;
    @(posedge clk);
    #1;
    valid_in  = 1'b1;
    func70_in = 1'b1;
    opcode_in = w ? 7'b0111011 : 7'b0110011;
    func3_in  = f3;
    rs1_val   = a;
    rs2_val   = b;
    rd_in     = rd;
    if (track) begin
      lat           = isSpecial(f3, w, a, b) ? 1 : 65;
      e.res         = refModel(f3, w, a, b);
      e.rd          = rd;
      e.doneCycle   = cyc + lat;
      e.stallCycles = lat;
      sb.push_back(e);
      lastResult    = e.res;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rs1_val  = $urandom();
    rs2_val  = $urandom();
  endtask

  task automatic waitDone();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      nComp++;
      nFail++;
      $display("[TB] FAIL completion_timeout: %0d results still pending", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every result_valid and checks value, rd, timing and stall length.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stallRun = 0;
    end else if (result_valid) begin
      if (sb.size() == 0) begin
        nComp++;
        nFail++;
        $display("[TB] FAIL unexpected_result_valid: result %h rd %0d expected none", result, rd_out);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("rd_out", {59'b0, rd_out}, {59'b0, e.rd});
        checkOutput("latency", 64'(cyc), 64'(e.doneCycle));
        checkOutput("stall_cycles", 64'(stallRun), 64'(e.stallCycles));
      end
      stallRun = 0;
    end else if (stall_out) begin
      stallRun++;
    end else begin
      stallRun = 0;
    end
  end

  function automatic logic [63:0] pickOperand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'h0;
      1:       v = '1;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h0000_0000_8000_0000;
      4:       v = 64'(int'($urandom_range(0, 40)) - 20);
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    logic [2:0] f3;
    logic       w;
    logic [2:0] wOps[5];
    wOps[0] = 3'b000; wOps[1] = 3'b100; wOps[2] = 3'b101; wOps[3] = 3'b110; wOps[4] = 3'b111;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_result", result, 64'h0);
    checkOutput("reset_rd", {59'b0, rd_out}, 64'h0);
    checkOutput("reset_valid", {63'b0, result_valid}, 64'h0);
    checkOutput("reset_stall", {63'b0, stall_out}, 64'h0);

    applyStimulus(3'b000, 1'b0, 64'd7, -64'sd3, 5'd5, 1'b1);  waitDone();
    applyStimulus(3'b011, 1'b0, '1, '1, 5'd6, 1'b1);           waitDone();
    applyStimulus(3'b001, 1'b0, '1, '1, 5'd7, 1'b1);           waitDone();
    applyStimulus(3'b100, 1'b0, -64'sd20, 64'd6, 5'd8, 1'b1);  waitDone();
    applyStimulus(3'b110, 1'b0, -64'sd20, 64'd6, 5'd9, 1'b1);  waitDone();
    applyStimulus(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd10, 1'b1); waitDone();
    applyStimulus(3'b101, 1'b0, 64'd123, 64'd0, 5'd11, 1'b1);  waitDone();
    applyStimulus(3'b111, 1'b0, 64'd123, 64'd0, 5'd12, 1'b1);  waitDone();
    applyStimulus(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd13, 1'b1); waitDone();
    applyStimulus(3'b010, 1'b0, -64'sd5, 64'd3, 5'd14, 1'b1);  waitDone();

    // Flush 20 cycles into a DIV: stall drops immediately and no result appears.
    applyStimulus(3'b100, 1'b0, 64'd100, 64'd7, 5'd20, 1'b0);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    #1 checkOutput("flush_stall_same_cycle", {63'b0, stall_out}, 64'h0);
    @(posedge clk);
    #1 flush = 1'b0;
    #1 checkOutput("flush_idle_stall", {63'b0, stall_out}, 64'h0);
    checkOutput("flush_idle_valid", {63'b0, result_valid}, 64'h0);
    repeat (70) @(posedge clk);
    checkOutput("flush_result_hold", result, lastResult);

    // Flush coinciding with an M op in IDLE must not accept it.
    @(posedge clk);
    #1;
    valid_in = 1'b1; func70_in = 1'b1; opcode_in = 7'b0110011; func3_in = 3'b000;
    rs1_val = 64'd9; rs2_val = 64'd9; rd_in = 5'd3; flush = 1'b1;
    #1 checkOutput("flush_accept_stall", {63'b0, stall_out}, 64'h0);
    @(posedge clk);
    #1 valid_in = 1'b0; flush = 1'b0;
    #1 checkOutput("flush_accept_idle", {63'b0, stall_out}, 64'h0);
    repeat (70) @(posedge clk);
    checkOutput("flush_accept_hold", result, lastResult);

    // Reset 30 cycles into a MUL, then a clean 2x3.
    applyStimulus(3'b000, 1'b0, 64'd11, 64'd13, 5'd21, 1'b0);
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 checkOutput("midreset_result", result, 64'h0);
    checkOutput("midreset_rd", {59'b0, rd_out}, 64'h0);
    checkOutput("midreset_stall", {63'b0, stall_out}, 64'h0);
    checkOutput("midreset_valid", {63'b0, result_valid}, 64'h0);
    applyStimulus(3'b000, 1'b0, 64'd2, 64'd3, 5'd22, 1'b1);
    waitDone();
    repeat (5) @(posedge clk);

    // Bubble with an M opcode never stalls.
    #1;
    valid_in = 1'b0; func70_in = 1'b1; opcode_in = 7'b0110011; func3_in = 3'b100;
    rs1_val = 64'd50; rs2_val = 64'd5;
    #1 checkOutput("bubble_stall", {63'b0, stall_out}, 64'h0);
    @(posedge clk);
    #1 checkOutput("bubble_stall_next", {63'b0, stall_out}, 64'h0);

    for (int i = 0; i < 40; i++) begin
      w  = ($urandom_range(0, 3) == 0);
      f3 = w ? wOps[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      applyStimulus(f3, w, pickOperand(), pickOperand(), 5'($urandom_range(0, 31)), 1'b1);
      waitDone();
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nComp, nFail);
    $finish;
  end

endmodule
